// File: rtl/clock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clock_monitor
// Purpose  : Counts rising edges of a slow clock-like input per fixed window,
//            reports count with an in-range flag, and flags loss of clock.
// Revision : 1.0 - initial release
// ============================================================================
module clock_monitor #(
  parameter int WINDOW  = 28000,
  parameter int LO      = 3490,
  parameter int HI      = 3510,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i,
  output logic [15:0] count,
  output logic        valid,
  output logic        ok,
  output logic        lost
);

  localparam logic [15:0] C_WEND = 16'(WINDOW - 1);
  localparam logic [15:0] C_TEND = 16'(TIMEOUT - 1);
  localparam logic [15:0] C_TMAX = 16'(TIMEOUT);
  localparam logic [15:0] C_SAT  = 16'hFFFF;
  localparam logic [31:0] C_LO   = 32'(LO);
  localparam logic [31:0] C_HI   = 32'(HI);

  typedef enum logic [0:0] {
    ST_WAIT    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [15:0] r_ecnt;
  logic [15:0] r_wcnt;
  logic [15:0] r_scnt;
  logic [15:0] w_ecnt_nxt;
  logic [15:0] w_wcnt_nxt;
  logic [15:0] w_scnt_nxt;
  logic [15:0] w_count_nxt;
  logic        w_valid_nxt;
  logic        w_ok_nxt;
  logic        w_lost_nxt;
  logic        w_rise;
  logic        w_timeout;
  logic        w_eow;
  logic        w_in_range;
  logic [15:0] w_ecnt_inc;
  logic [15:0] w_closing;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise     = r_sync2 & ~r_prev;
  // Fires on the edge that takes the stall counter to TIMEOUT.
  assign w_timeout  = ~w_rise & (r_scnt == C_TEND);
  assign w_eow      = (r_state == ST_MEASURE) & (r_wcnt == C_WEND);
  assign w_ecnt_inc = (r_ecnt == C_SAT) ? C_SAT : r_ecnt + 16'd1;
  assign w_closing  = w_rise ? w_ecnt_inc : r_ecnt;
  assign w_in_range = ({16'd0, w_closing} >= C_LO) && ({16'd0, w_closing} <= C_HI);
  assign w_scnt_nxt = w_rise ? 16'd0 : ((r_scnt >= C_TMAX) ? r_scnt : r_scnt + 16'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_ecnt_nxt  = r_ecnt;
    w_wcnt_nxt  = r_wcnt;
    w_count_nxt = count;
    w_valid_nxt = 1'b0;
    w_ok_nxt    = ok;
    w_lost_nxt  = lost;
    if (w_timeout) begin
      w_state_nxt = ST_WAIT;
      w_ecnt_nxt  = 16'd0;
      w_wcnt_nxt  = 16'd0;
      w_ok_nxt    = 1'b0;
      w_lost_nxt  = 1'b1;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_rise) begin
            w_state_nxt = ST_MEASURE;
            w_ecnt_nxt  = 16'd1;
            w_wcnt_nxt  = 16'd1;
            w_lost_nxt  = 1'b0;
          end
        end
        ST_MEASURE: begin
          if (w_eow) begin
            w_count_nxt = w_closing;
            w_ok_nxt    = w_in_range;
            w_valid_nxt = 1'b1;
            w_ecnt_nxt  = 16'd0;
            w_wcnt_nxt  = 16'd0;
          end else begin
            w_ecnt_nxt  = w_closing;
            w_wcnt_nxt  = r_wcnt + 16'd1;
          end
        end
        default: w_state_nxt = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_WAIT;
      r_ecnt  <= 16'd0;
      r_wcnt  <= 16'd0;
      r_scnt  <= 16'd0;
      count   <= 16'd0;
      valid   <= 1'b0;
      ok      <= 1'b0;
      lost    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ecnt  <= w_ecnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_scnt  <= w_scnt_nxt;
      count   <= w_count_nxt;
      valid   <= w_valid_nxt;
      ok      <= w_ok_nxt;
      lost    <= w_lost_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_monitor.sv
`default_nettype none
// Testbench for clock_monitor: directed scenarios plus random pulse trains,
// checked every cycle against a timestamp-based reference model.
module tb_clock_monitor;

  localparam int WINDOW  = 100;
  localparam int LO      = 24;
  localparam int HI      = 26;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i     = 1'b0;
  logic [15:0] d_count;
  logic        d_valid;
  logic        d_ok;
  logic        d_lost;

  clock_monitor #(
    .WINDOW (WINDOW),
    .LO     (LO),
    .HI     (HI),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i    (i),
    .count(d_count),
    .valid(d_valid),
    .ok   (d_ok),
    .lost (d_lost)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   n = 0;
  logic h0, h1, h2, h3;
  bit   m_meas;
  int   m_wstart, m_last, m_ecnt, m_count;
  bit   m_valid, m_ok, m_lost;
  int   nvalid, v_edge, v_count, lost_edge, last_hi;
  bit   v_ok, lost_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: a rise takes effect 2 edges after i is first sampled high.
  task automatic tick(input logic val);
    logic r;
    i = val;
    @(posedge clock);
    n++;
    h3 = h2; h2 = h1; h1 = h0; h0 = val;
    r = h2 & ~h3;
    m_valid = 1'b0;
    if (!r && (n - m_last == TIMEOUT)) begin
      m_meas = 1'b0; m_ok = 1'b0; m_lost = 1'b1;
    end else if (!m_meas) begin
      if (r) begin
        m_meas = 1'b1; m_wstart = n; m_ecnt = 1; m_lost = 1'b0;
      end
    end else begin
      m_ecnt += int'(r);
      if ((n - m_wstart) % WINDOW == WINDOW - 1) begin
        m_count = (m_ecnt > 65535) ? 65535 : m_ecnt;
        m_ok    = (m_count >= LO) && (m_count <= HI);
        m_valid = 1'b1;
        m_ecnt  = 0;
      end
    end
    if (r) m_last = n;
    #1;
    chk("count", d_count, m_count);
    chk("valid", d_valid, m_valid);
    chk("ok",    d_ok,    m_ok);
    chk("lost",  d_lost,  m_lost);
    if (d_valid) begin
      nvalid++; v_edge = n; v_count = d_count; v_ok = d_ok;
    end
    if (d_lost && !lost_prev) lost_edge = n;
    lost_prev = d_lost;
  endtask

  task automatic pulse(input int hi, input int lo);
    last_hi = n + 1;
    repeat (hi) tick(1'b1);
    repeat (lo) tick(1'b0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_count", d_count, 0);
    chk("rst_valid", d_valid, 0);
    chk("rst_ok",    d_ok,    0);
    chk("rst_lost",  d_lost,  1);
    h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    m_meas = 0; m_count = 0; m_ok = 0; m_valid = 0; m_lost = 1; m_ecnt = 0;
    m_last = n; lost_prev = 1'b1;
    #1 reset = 1'b0;
  endtask

  function automatic int next_eow(input int after);
    int t;
    t = m_wstart + WINDOW - 1;
    while (t < after) t += WINDOW;
    return t;
  endfunction

  initial begin
    int t_eow, s_hi, rs, rn;
    h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    m_meas = 0; m_count = 0; m_ok = 0; m_valid = 0; m_lost = 1;
    m_last = 0; m_wstart = 0; m_ecnt = 0;
    lost_prev = 1'b1; nvalid = 0; v_edge = -1; v_count = -1; v_ok = 0;
    lost_edge = -1; last_hi = 0;

    repeat (3) @(posedge clock);
    #1;
    chk("init_count", d_count, 0);
    chk("init_valid", d_valid, 0);
    chk("init_ok",    d_ok,    0);
    chk("init_lost",  d_lost,  1);
    reset = 1'b0;

    // Period 4: 25 edges per window, in range.
    nvalid = 0;
    repeat (90) pulse(2, 2);
    chk("p4_nvalid", nvalid, 3);
    chk("p4_count", v_count, 25);
    chk("p4_ok", v_ok, 1);
    chk("p4_lost", d_lost, 0);

    // Period 5: 20 edges per window, out of range.
    nvalid = 0;
    repeat (60) pulse(2, 3);
    chk("p5_nvalid", nvalid, 3);
    chk("p5_count", v_count, 20);
    chk("p5_ok", v_ok, 0);
    chk("p5_lost", d_lost, 0);

    // Stall mid-window, far from a window end.
    for (int k = 0; k < 30 && (next_eow(n + 1) - n) <= 40; k++) pulse(2, 3);
    nvalid = 0;
    repeat (30) tick(1'b0);
    chk("stall_delay", lost_edge - (last_hi + 2), TIMEOUT);
    chk("stall_nvalid", nvalid, 0);
    chk("stall_count", d_count, 20);
    chk("stall_ok", d_ok, 0);
    chk("stall_lost", d_lost, 1);

    // Recovery: first valid WINDOW-1 edges after the recovering rise.
    nvalid = 0;
    rs = n + 1;
    repeat (30) pulse(2, 2);
    chk("rec_nvalid", nvalid, 1);
    chk("rec_edge", v_edge, rs + 2 + WINDOW - 1);
    chk("rec_count", v_count, 25);
    chk("rec_ok", v_ok, 1);

    // Rise landing exactly on the end-of-window edge.
    t_eow = next_eow(n + 10);
    s_hi  = t_eow - 2;
    for (int k = 0; k < 40 && (s_hi - (n + 1)) >= 4; k++) pulse(2, 2);
    repeat (s_hi - (n + 1)) tick(1'b0);
    pulse(2, 2);
    chk("eow_edge", v_edge, t_eow);
    chk("eow_count", v_count, m_count);
    repeat (25) pulse(2, 2);
    chk("eow_next_edge", v_edge, t_eow + WINDOW);
    chk("eow_next_count", v_count, 25);

    // Reset in the middle of a window.
    for (int k = 0; k < 200 && ((n - m_wstart) % WINDOW != 49); k++) tick((k % 4) < 2);
    nvalid = 0;
    rn = n;
    do_reset();
    repeat (30) pulse(2, 2);
    chk("rst_nvalid", nvalid, 1);
    chk("rst_edge", v_edge, rn + 1 + 2 + WINDOW - 1);
    chk("rst_wcount", v_count, 25);

    // Timeout coinciding with the end of window: timeout wins.
    t_eow = next_eow(n + 30);
    s_hi  = t_eow - TIMEOUT - 2;
    for (int k = 0; k < 40 && (s_hi - (n + 1)) >= 4; k++) pulse(2, 2);
    repeat (s_hi - (n + 1)) tick(1'b0);
    nvalid = 0;
    tick(1'b1);
    tick(1'b1);
    repeat (30) tick(1'b0);
    chk("coin_nvalid", nvalid, 0);
    chk("coin_lost_edge", lost_edge, t_eow);
    chk("coin_lost", d_lost, 1);
    chk("coin_ok", d_ok, 0);

    // Random pulse trains within the legal phase limits.
    repeat (40) pulse($urandom_range(2, 5), $urandom_range(2, 5));
    repeat (120) pulse(2, 2);
    chk("rand_lost", d_lost, 0);
    chk("rand_final_count", v_count, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
